// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One operation at a time: a start in IDLE captures the operands and op. The unit then runs
// WIDTH shift-add (multiply) or restoring shift-subtract (divide) iterations, and in FINISH
// writes the sign-corrected result to HI/LO. The result is visible WIDTH+1 edges after start.
//
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   start  launch op when not busy
//   op     00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b   rs / rt operands (a is also MTHI/MTLO data)
//   hi_we  MTHI (hi <= a) when idle and not starting
//   lo_we  MTLO (lo <= a) when idle and not starting
//   busy   operation in progress
//   done   one-cycle pulse after HI/LO take a mul/div result
//   hi, lo HI/LO registers
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q_q, neg_q_d;     // negate product / quotient
  logic             neg_r_q, neg_r_d;     // negate remainder
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] operand_q, operand_d; // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fin;
  logic [WIDTH-1:0] quot_fin, rem_fin;

  always_comb begin
    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    // Multiply step: conditionally add multiplicand to the high half, then shift right,
    // keeping the carry as the new top bit.
    mul_sum = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? operand_q : {WIDTH{1'b0}})};

    // Divide step: shift the next dividend bit into the remainder and compare with divisor.
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, operand_q};

    prod     = {acc_hi_q, acc_lo_q};
    prod_fin = neg_q_q ? -prod : prod;
    quot_fin = div0_q ? {WIDTH{1'b1}} : (neg_q_q ? -acc_lo_q : acc_lo_q);
    // With a zero divisor the remainder is |a|, so restoring a's sign yields the original a.
    rem_fin  = neg_r_q ? -acc_hi_q : acc_hi_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    div0_d    = div0_q;
    operand_d = operand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          cnt_d    = CntW'(WIDTH - 1);
          is_div_d = op[1];
          neg_q_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          div0_d   = op[1] & (b == '0);
          acc_hi_d = '0;
          if (op[1]) begin
            acc_lo_d  = a_mag;
            operand_d = b_mag;
          end else begin
            acc_lo_d  = b_mag;
            operand_d = a_mag;
          end
        end else begin
          if (hi_we) hi_d = a;
          if (lo_we) lo_d = a;
        end
      end
      StRun: begin
        if (is_div_q) begin
          // Modular subtract is exact: when div_ge the difference is below the divisor.
          acc_hi_d = div_ge ? (div_shift[WIDTH-1:0] - operand_q) : div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = StFinish;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFinish: begin
        if (is_div_q) begin
          hi_d = rem_fin;
          lo_d = quot_fin;
        end else begin
          hi_d = prod_fin[2*WIDTH-1:WIDTH];
          lo_d = prod_fin[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      div0_q    <= 1'b0;
      operand_q <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      div0_q    <= div0_d;
      operand_q <= operand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic [63:0] exp_res;

  // Reference: {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma,
                                        input logic [31:0] mb);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'(signed'(ma));
    sb = longint'(signed'(mb));
    case (mop)
      2'd0: res = {32'd0, ma} * {32'd0, mb};
      2'd1: res = sa * sb;
      2'd2: res = (mb == 0) ? {ma, 32'hFFFF_FFFF} : {ma % mb, ma / mb};
      default: begin
        if (mb == 0) begin
          res = {ma, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic launch(input logic [1:0] lop, input logic [31:0] la, input logic [31:0] lb);
    start = 1'b1;
    op = lop;
    a = la;
    b = lb;
    exp_res = model(lop, la, lb);
    step();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // Waits for done (bounded), then checks latency, busy behaviour and HI/LO.
  // Leaves the bench in the done cycle.
  task automatic finish_check(input string tag);
    int busy_low;
    busy_low = 0;
    while (done !== 1'b1 && (cyc - start_cyc) < 100) begin
      if (busy !== 1'b1) busy_low++;
      step();
    end
    check({tag, "_latency"}, 64'(cyc - start_cyc), 64'(W + 1));
    check({tag, "_busy_run"}, 64'(busy_low), 64'd0);
    check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
    check({tag, "_hilo"}, {hi, lo}, exp_res);
  endtask

  task automatic run_check(input string tag, input logic [1:0] lop, input logic [31:0] la,
                           input logic [31:0] lb);
    launch(lop, la, lb);
    finish_check(tag);
  endtask

  initial begin
    int done_cnt;
    logic [1:0] rop;
    logic [31:0] ra, rb;

    // Reset and idle
    step();
    step();
    rst = 1'b0;
    step();
    step();
    step();
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);

    // MTLO, then MTHI+MTLO together
    lo_we = 1'b1;
    a = 32'h1234_5678;
    step();
    lo_we = 1'b0;
    check("mtlo", {hi, lo}, {32'd0, 32'h1234_5678});
    hi_we = 1'b1;
    lo_we = 1'b1;
    a = 32'hA5A5_0F0F;
    step();
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mthilo", {hi, lo}, {32'hA5A5_0F0F, 32'hA5A5_0F0F});

    // Directed operations
    run_check("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_exp", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
    step();
    check("done_pulse", {63'd0, done}, 64'd0);
    run_check("mult_neg", 2'd1, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg_exp", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_check("div_neg", 2'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_exp", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_check("divu_zero", 2'd2, 32'd100, 32'd0);
    check("divu_zero_exp", {hi, lo}, {32'h0000_0064, 32'hFFFF_FFFF});
    run_check("div_zero_neg", 2'd3, 32'hFFFF_FFF0, 32'd0);
    run_check("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_exp", {hi, lo}, {32'h0000_0000, 32'h8000_0000});
    step();

    // Start / MTHI while busy are ignored; operands changing mid-run have no effect
    launch(2'd2, 32'd100, 32'd7);
    step();
    step();
    step();
    step();
    start = 1'b1;
    op = 2'd0;
    a = 32'd2;
    b = 32'd2;
    hi_we = 1'b1;
    step();
    start = 1'b0;
    hi_we = 1'b0;
    a = 32'h0BAD_0BAD;
    finish_check("busy_ignore");
    check("busy_ignore_exp", {hi, lo}, {32'd2, 32'd14});

    // Back-to-back: start in the done cycle
    run_check("b2b", 2'd1, 32'h8000_0000, 32'h8000_0000);

    // Randomized operations, all issued back-to-back
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_check($sformatf("rand%0d", i), rop, ra, rb);
    end
    step();

    // Reset in the middle of an operation
    launch(2'd0, 32'd5, 32'd6);
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) done_cnt++;
    end
    check("midrst_nodone", 64'(done_cnt), 64'd0);
    check("midrst_hilo_after", {hi, lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
